approx_err_monitor: RTL

Streaming error-characterization block for the approximate adder datapath. It consumes operand/result samples produced by an approximate W-bit adder chain and recomputes the exact sum for each sample. Over a window of N_SAMPLES accepted samples it accumulates the error count, the saturating sum of absolute error and the maximum absolute error. It sits on the observation side of the approximate adder, between the adder under evaluation and the test/readout logic.

---
 rtl/approx_err_monitor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/approx_err_monitor.sv
// Error characterization for an approximate W-bit adder: recomputes the exact sum per sample
// and accumulates error count, saturating sum of |error| and max |error| over a window.
module approx_err_monitor #(
    parameter int W         = 8,
    parameter int N_SAMPLES = 256,
    parameter int ACC_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [W-1:0]                   a,
    input  logic [W-1:0]                   b,
    input  logic                           cin,
    input  logic [W:0]                     approx_s,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(N_SAMPLES+1)-1:0] err_count,
    output logic [ACC_W-1:0]               sum_abs_err,
    output logic [W:0]                     max_abs_err
);
    localparam int CNT_W = $clog2(N_SAMPLES+1);
    localparam int SUM_W = ((ACC_W > W+1) ? ACC_W : W+1) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nx;
    logic             clear;
    logic             accept;
    logic [CNT_W-1:0] acc_cnt;

    logic             vld_p1, vld_p2;
    logic [W:0]       exact_p1, approx_p1;
    logic [W:0]       diff_p2;

    function automatic logic [W:0] exact_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic [W:0] abs_diff(input logic [W:0] e, input logic [W:0] q);
        logic signed [W+1:0] d;
        logic signed [W+1:0] m;
        d = $signed({1'b0, e}) - $signed({1'b0, q});
        m = (d < 0) ? -d : d;
        return m[W:0];
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc, input logic [W:0] d);
        logic [SUM_W-1:0] s;
        s = SUM_W'(acc) + SUM_W'(d);
        return (s > SUM_W'(ACC_MAX)) ? ACC_MAX : s[ACC_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        clear    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    clear    = 1'b1;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = (acc_cnt < LAST_CNT);
                if (acc_cnt == LAST_CNT) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!vld_p1 && !vld_p2) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nx = RUN;
                    clear    = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else if (clear) begin
            acc_cnt <= '0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
        end
    end

    // stage 1: exact sum and approximate result; stage 2: absolute error
    always_ff @(posedge clk) begin
        if (accept) begin
            exact_p1  <= exact_sum(a, b, cin);
            approx_p1 <= approx_s;
        end
        if (vld_p1) diff_p2 <= abs_diff(exact_p1, approx_p1);
    end

    // accumulators: results of the window, cleared on entry to RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (clear) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (vld_p2) begin
            if (diff_p2 != '0)        err_count <= err_count + CNT_W'(1);
            sum_abs_err <= sat_add(sum_abs_err, diff_p2);
            if (diff_p2 > max_abs_err) max_abs_err <= diff_p2;
        end
    end
endmodule
